// File: rtl/trace_pkg.sv
// Shared types and defaults for the retirement-trace capture unit.
package trace_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_SEQ_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]          pc;
    logic [DEF_SEQ_W-1:0] seq;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace entries with flush; pointers carry an
// extra MSB so full and empty are distinguishable without a separate count.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int  DEPTH   = DEF_DEPTH,
  parameter type entry_t = trace_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   wdata,
  output entry_t                   rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // A push into a full FIFO is accepted only when the head is leaving the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/trace_buffer.sv
// Captures retired-instruction PCs into a FIFO after an arm/trigger sequence,
// and keeps free-running cycle and retire counters for CPI measurement.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int SEQ_W = DEF_SEQ_W
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [31:0]              i_pc_debug,
  input  logic                     i_insn_vld,
  input  logic                     i_arm,
  input  logic                     i_stop,
  input  logic                     i_clear,
  input  logic [31:0]              i_trig_pc,
  output logic [1:0]               o_state,
  output logic                     o_trace_valid,
  input  logic                     i_trace_ready,
  output logic [31:0]              o_trace_pc,
  output logic [SEQ_W-1:0]         o_trace_seq,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_ovf,
  output logic [SEQ_W-1:0]         o_drop_count,
  output logic [31:0]              o_retired_count,
  output logic [31:0]              o_cycle_count
);

  typedef struct packed {
    logic [31:0]      pc;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  state_t  state;
  state_t  state_next;
  logic    trigger;
  logic    push;
  logic    pop;
  logic    drop;
  logic    full;
  logic    empty;
  entry_t  wdata;
  entry_t  head;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    trigger    = 1'b0;
    if (i_clear || i_stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_arm) state_next = ARMED;
        ARMED: begin
          if (i_insn_vld && (i_pc_debug == i_trig_pc)) begin
            trigger    = 1'b1;
            state_next = CAPTURE;
          end
        end
        CAPTURE: state_next = CAPTURE;
        default: state_next = IDLE;
      endcase
    end
  end

  // The trigger instruction itself is captured on the same edge that enters CAPTURE.
  assign push = !i_clear && i_insn_vld && ((state == CAPTURE) || trigger);
  assign pop  = o_trace_valid && i_trace_ready;
  assign drop = push && full && !pop;

  assign wdata.pc  = i_pc_debug;
  assign wdata.seq = o_retired_count[SEQ_W-1:0];

  trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (i_clk),
    .reset (i_reset),
    .flush (i_clear),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (o_level)
  );

  assign o_state       = state;
  assign o_trace_valid = !empty;
  assign o_trace_pc    = o_trace_valid ? head.pc  : '0;
  assign o_trace_seq   = o_trace_valid ? head.seq : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      o_cycle_count   <= '0;
      o_retired_count <= '0;
      o_ovf           <= 1'b0;
      o_drop_count    <= '0;
    end else begin
      o_cycle_count   <= o_cycle_count + 32'd1;
      o_retired_count <= o_retired_count + {31'd0, i_insn_vld};
      if (drop) begin
        o_ovf <= 1'b1;
        if (o_drop_count != {SEQ_W{1'b1}}) o_drop_count <= o_drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: a queue-based model checked every cycle,
// plus literal expectations on the drained trace and on counter values.
module tb_trace_buffer;

  localparam int DEPTH = 16;
  localparam int SEQ_W = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        vld = 1'b0;
  logic        arm = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] trig = '0;
  logic        ready = 1'b0;

  logic [1:0]             state;
  logic                   tvalid;
  logic [31:0]            tpc;
  logic [SEQ_W-1:0]       tseq;
  logic [$clog2(DEPTH):0] level;
  logic                   ovf;
  logic [SEQ_W-1:0]       drop_count;
  logic [31:0]            retired;
  logic [31:0]            cycles;

  trace_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_pc_debug      (pc),
    .i_insn_vld      (vld),
    .i_arm           (arm),
    .i_stop          (stop),
    .i_clear         (clear),
    .i_trig_pc       (trig),
    .o_state         (state),
    .o_trace_valid   (tvalid),
    .i_trace_ready   (ready),
    .o_trace_pc      (tpc),
    .o_trace_seq     (tseq),
    .o_level         (level),
    .o_ovf           (ovf),
    .o_drop_count    (drop_count),
    .o_retired_count (retired),
    .o_cycle_count   (cycles)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of {pc, seq} plus plain counters.
  typedef struct {
    logic [31:0] pc;
    logic [15:0] seq;
  } ent_t;

  ent_t        q[$];
  int          m_state = 0;
  logic [31:0] m_cyc = '0;
  logic [31:0] m_ret = '0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_drop = '0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    bit   do_pop, do_push, trg, was_full;
    ent_t e;
    started = 1'b1;
    if (reset || clear) begin
      q.delete();
      m_state = 0; m_cyc = '0; m_ret = '0; m_ovf = 1'b0; m_drop = '0;
    end else begin
      do_pop   = ready && (q.size() != 0);
      trg      = (m_state == 1) && vld && (pc == trig) && !stop;
      do_push  = vld && ((m_state == 2) || trg);
      was_full = (q.size() == DEPTH);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        if (!was_full || do_pop) begin
          e.pc = pc; e.seq = m_ret[15:0];
          q.push_back(e);
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
      end
      if (stop)                     m_state = 0;
      else if (m_state == 0 && arm) m_state = 1;
      else if (trg)                 m_state = 2;
      m_cyc = m_cyc + 32'd1;
      if (vld) m_ret = m_ret + 32'd1;
    end
  end

  logic [31:0] log_pc[$];
  logic [15:0] log_seq[$];

  // Per-cycle compare against the model, and record every accepted head.
  always @(negedge clk) begin
    if (started) begin
      chk("state", 64'(state), 64'(m_state));
      chk("valid", 64'(tvalid), 64'(q.size() != 0));
      chk("level", 64'(level), 64'(q.size()));
      chk("ovf", 64'(ovf), 64'(m_ovf));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      chk("retired", 64'(retired), 64'(m_ret));
      chk("cycles", 64'(cycles), 64'(m_cyc));
      if (q.size() != 0) begin
        chk("head_pc", 64'(tpc), 64'(q[0].pc));
        chk("head_seq", 64'(tseq), 64'(q[0].seq));
      end
      if (tvalid && ready) begin
        log_pc.push_back(tpc);
        log_seq.push_back(tseq);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input int idx, input logic [31:0] epc, input logic [15:0] eseq);
    if (idx >= log_pc.size()) begin
      chk("log_present", 64'(log_pc.size()), 64'(idx + 1));
    end else begin
      chk("log_pc", 64'(log_pc[idx]), 64'(epc));
      chk("log_seq", 64'(log_seq[idx]), 64'(eseq));
    end
  endtask

  initial begin
    // Reset, then 10 idle cycles with the retire strobe toggling.
    repeat (2) step();
    reset = 1'b0;
    chk("rst_cycles", 64'(cycles), 64'd0);
    chk("rst_valid", 64'(tvalid), 64'd0);
    for (int i = 0; i < 10; i++) begin
      vld = (i % 2) == 1;
      pc  = 32'h1000 + 32'(i * 4);
      step();
    end
    vld = 1'b0;
    chk("idle_cycles", 64'(cycles), 64'd10);
    chk("idle_retired", 64'(retired), 64'd5);
    chk("idle_state", 64'(state), 64'd0);

    // Trigger at 0x10 while retiring 0x0..0x1C with the host always ready.
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_cycles", 64'(cycles), 64'd0);
    chk("clr_retired", 64'(retired), 64'd0);
    trig = 32'h10; arm = 1'b1; step(); arm = 1'b0;
    chk("armed", 64'(state), 64'd1);
    ready = 1'b1;
    log_pc.delete(); log_seq.delete();
    for (int k = 0; k < 8; k++) begin
      pc = 32'(k * 4); vld = 1'b1; step();
    end
    vld = 1'b0;
    repeat (4) step();
    chk("trig_count", 64'(log_pc.size()), 64'd4);
    chk_log(0, 32'h10, 16'd4);
    chk_log(1, 32'h14, 16'd5);
    chk_log(2, 32'h18, 16'd6);
    chk_log(3, 32'h1C, 16'd7);
    chk("capture", 64'(state), 64'd2);

    // Overflow: 20 captured retires into a 16-deep FIFO with no drain.
    stop = 1'b1; step(); stop = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    trig = 32'h100; arm = 1'b1; step(); arm = 1'b0;
    ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      pc = 32'h100 + 32'(k * 4); vld = 1'b1; step();
    end
    vld = 1'b0;
    chk("ovf_level", 64'(level), 64'd16);
    chk("ovf_flag", 64'(ovf), 64'd1);
    chk("ovf_drops", 64'(drop_count), 64'd4);
    chk("ovf_head_seq", 64'(tseq), 64'd0);

    // Full FIFO with a simultaneous push and pop.
    ready = 1'b1; pc = 32'h200; vld = 1'b1; step();
    ready = 1'b0; vld = 1'b0;
    chk("pp_level", 64'(level), 64'd16);
    chk("pp_drops", 64'(drop_count), 64'd4);
    log_pc.delete(); log_seq.delete();
    ready = 1'b1;
    repeat (18) step();
    ready = 1'b0;
    chk("drain_count", 64'(log_pc.size()), 64'd16);
    chk_log(0, 32'h104, 16'd1);
    chk_log(14, 32'h13C, 16'd15);
    chk_log(15, 32'h200, 16'd20);

    // Refill to full, then clear on the same cycle as a would-be push.
    for (int k = 0; k < 16; k++) begin
      pc = 32'h300 + 32'(k * 4); vld = 1'b1; step();
    end
    chk("refill_level", 64'(level), 64'd16);
    pc = 32'h380; clear = 1'b1; step();
    clear = 1'b0; vld = 1'b0;
    chk("clr_level", 64'(level), 64'd0);
    chk("clr_ovf", 64'(ovf), 64'd0);
    chk("clr_drops", 64'(drop_count), 64'd0);
    chk("clr_cyc", 64'(cycles), 64'd0);
    chk("clr_state", 64'(state), 64'd0);

    // Stop with three entries queued; later retires are ignored.
    trig = 32'h400; arm = 1'b1; step(); arm = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pc = 32'h400 + 32'(k * 4); vld = 1'b1; step();
    end
    vld = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    for (int k = 3; k < 5; k++) begin
      pc = 32'h400 + 32'(k * 4); vld = 1'b1; step();
    end
    vld = 1'b0;
    chk("stop_level", 64'(level), 64'd3);
    chk("stop_state", 64'(state), 64'd0);
    log_pc.delete(); log_seq.delete();
    ready = 1'b1;
    repeat (5) step();
    ready = 1'b0;
    chk("stop_count", 64'(log_pc.size()), 64'd3);
    chk_log(0, 32'h400, 16'd0);
    chk_log(1, 32'h404, 16'd1);
    chk_log(2, 32'h408, 16'd2);

    // Reset mid-drain behaves like clear.
    arm = 1'b1; step(); arm = 1'b0;
    pc = 32'h408; vld = 1'b1; step(); vld = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst2_valid", 64'(tvalid), 64'd0);
    chk("rst2_retired", 64'(retired), 64'd0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
